// File: rtl/exp_alu.sv
// exp_alu: registered exponent compare for the FP adder; yields larger-or-equal flag,
// absolute difference (alignment shift amount) and the larger exponent.
module exp_alu #(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         in_valid,
    input  logic [N-1:0] exp_a,
    input  logic [N-1:0] exp_b,
    output logic         out_valid,
    output logic         exp_set,
    output logic [N-1:0] exp_diff,
    output logic [N-1:0] exp_max
);
    logic [N:0]   diff_ab;
    logic [N:0]   diff_ba;
    logic         set;
    logic [N-1:0] diff;
    logic [N-1:0] max;
    // The N+1-bit borrow doubles as the comparison; bias cancels so encodings compare directly.
    always_comb begin
        diff_ab = {1'b0, exp_a} - {1'b0, exp_b};
        diff_ba = {1'b0, exp_b} - {1'b0, exp_a};
        set     = ~diff_ab[N];
        diff    = set ? diff_ab[N-1:0] : diff_ba[N-1:0];
        max     = set ? exp_a : exp_b;
    end
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            exp_set   <= 1'b0;
            exp_diff  <= '0;
            exp_max   <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                exp_set  <= set;
                exp_diff <= diff;
                exp_max  <= max;
            end
        end
    end
endmodule

// File: tb/tb_exp_alu.sv
// tb_exp_alu: directed vectors and a full 1..254 sweep, checked against an integer model
// every cycle plus literal expectations that pin the model.
module tb_exp_alu;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] exp_a = '0;
    logic [7:0] exp_b = '0;
    logic       out_valid;
    logic       exp_set;
    logic [7:0] exp_diff;
    logic [7:0] exp_max;

    int n_vec = 0;
    int n_err = 0;

    int m_valid = 0, m_set = 0, m_diff = 0, m_max = 0;
    bit m_live = 0;

    exp_alu #(.N(8)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid),
        .exp_a(exp_a), .exp_b(exp_b), .out_valid(out_valid),
        .exp_set(exp_set), .exp_diff(exp_diff), .exp_max(exp_max)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, want, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on what the outputs must be after each edge.
    always @(posedge clock) begin
        if (!reset_n) begin
            m_valid = 0; m_set = 0; m_diff = 0; m_max = 0;
            m_live  = 1;
        end else begin
            m_valid = in_valid;
            if (in_valid) begin
                m_set  = (int'(exp_a) >= int'(exp_b)) ? 1 : 0;
                m_diff = (int'(exp_a) >= int'(exp_b)) ? int'(exp_a) - int'(exp_b) : int'(exp_b) - int'(exp_a);
                m_max  = (int'(exp_a) >= int'(exp_b)) ? int'(exp_a) : int'(exp_b);
            end
        end
    end

    always @(negedge clock) begin
        if (m_live) begin
            chk("model_valid", int'(out_valid), m_valid);
            chk("model_set",   int'(exp_set),   m_set);
            chk("model_diff",  int'(exp_diff),  m_diff);
            chk("model_max",   int'(exp_max),   m_max);
        end
    end

    task automatic step(input bit v, input int a, input int b);
        in_valid = v;
        exp_a    = 8'(a);
        exp_b    = 8'(b);
        @(posedge clock);
        #1;
    endtask

    task automatic lit(input string name, input int v, input int s, input int d, input int m);
        chk({name, "_valid"}, int'(out_valid), v);
        chk({name, "_set"},   int'(exp_set),   s);
        chk({name, "_diff"},  int'(exp_diff),  d);
        chk({name, "_max"},   int'(exp_max),   m);
    endtask

    initial begin
        reset_n = 1'b0;
        step(1, 77, 12);
        step(0, 0, 0);
        lit("reset", 0, 0, 0, 0);
        reset_n = 1'b1;

        step(1, 130, 127); lit("a_gt_b", 1, 1, 3, 130);
        step(1, 127, 130); lit("a_lt_b", 1, 0, 3, 130);
        step(1, 100, 100); lit("equal",  1, 1, 0, 100);
        step(1, 254, 1);   lit("ext_hi", 1, 1, 253, 254);
        step(1, 0, 255);   lit("ext_rs", 1, 0, 255, 255);
        step(1, 255, 0);   lit("ext_rv", 1, 1, 255, 255);

        step(1, 10, 20);   lit("hs_first", 1, 0, 10, 20);
        step(0, $urandom_range(255), $urandom_range(255));
        lit("hs_idle", 0, 0, 10, 20);
        step(1, 50, 5);    lit("hs_second", 1, 1, 45, 50);

        reset_n = 1'b0;
        step(1, 200, 3);   lit("rst_mid", 0, 0, 0, 0);
        reset_n = 1'b1;
        step(0, 9, 9);     lit("rst_idle", 0, 0, 0, 0);
        step(1, 7, 9);     lit("rst_after", 1, 0, 2, 9);

        for (int a = 1; a <= 254; a++)
            for (int b = 1; b <= 254; b++)
                step(1, a, b);
        step(0, 0, 0);
        step(0, 0, 0);
        @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/exp_alu.md
Name: exp_alu

Overview:
- Exponent ALU for the floating-point adder datapath; sits ahead of the mantissa alignment shifter.
- Compares two biased exponents and reports which operand is larger or equal.
- Reports the absolute difference, which becomes the alignment shift amount, and the larger exponent.
- Results are registered: one clock, synchronous active-low reset.

Parameters:
- N, default 8: exponent width in bits. Bias = 2^(N-1) - 1. Legal N >= 2.

Ports:
- Clock  input  1  rising-edge clock; the single clock of the block.
- Reset_n  input  1  synchronous, active-low reset.
- InValid  input  1  ExpA/ExpB are valid this cycle.
- ExpA  input  N  biased exponent of operand A, unsigned.
- ExpB  input  N  biased exponent of operand B, unsigned.
- OutValid  output  1  registered results are valid.
- ExpSet  output  1  1 when ExpA >= ExpB (A is the larger-or-equal operand).
- ExpDiff  output  N  |ExpA - ExpB|.
- ExpMax  output  N  max(ExpA, ExpB).

Behaviour:
- Reset: on a rising Clock edge with Reset_n = 0, OutValid, ExpSet, ExpDiff and ExpMax all become 0.
  - Reset overrides InValid on the same edge.
  - A transaction presented during reset is dropped.
  - Reset_n has no asynchronous effect.
- Latency: exactly 1 cycle. Inputs are sampled on the edge where InValid = 1. Results and OutValid = 1 appear after that edge.
- Throughput: one operation per cycle. Back-to-back InValid cycles produce back-to-back OutValid cycles.
- Idle: on an edge with InValid = 0 (and Reset_n = 1):
  - OutValid goes to 0.
  - ExpSet, ExpDiff and ExpMax hold their previous values.
- No backpressure; the consumer must accept results while OutValid = 1.
- Arithmetic:
  - Unsigned N-bit comparison of the biased encodings; bias cancels, so no unbiasing is performed.
  - ExpSet = (ExpA >= ExpB). Equality gives ExpSet = 1.
  - ExpDiff = ExpA - ExpB when ExpSet = 1, else ExpB - ExpA.
  - Subtraction is computed at N+1 bits. The result always fits in N bits (max 2^N - 1), so no truncation or wrap occurs.
  - ExpMax = ExpA when ExpSet = 1, else ExpB.
- All input encodings 0 .. 2^N - 1 are legal, including the reserved all-zeros and all-ones encodings. No special-casing.
- Outputs must not depend combinationally on the inputs.
- No X propagation after reset. Outputs are deterministic for all inputs.

Test Plan:
- Exhaustive sweep, N = 8: ExpA and ExpB each over 1..254 (unbiased -126..127), InValid = 1. One cycle later, every pair must give:
  - ExpSet = (ExpA >= ExpB)
  - ExpDiff = |unbiased A - unbiased B|
  - ExpMax = larger of the two
  - OutValid = 1
- Directed values:
  - ExpA = 130, ExpB = 127 -> ExpSet = 1, ExpDiff = 3, ExpMax = 130.
  - ExpA = 127, ExpB = 130 -> ExpSet = 0, ExpDiff = 3, ExpMax = 130.
- Equal and extreme values:
  - ExpA = ExpB = 100 -> ExpSet = 1, ExpDiff = 0, ExpMax = 100.
  - ExpA = 254, ExpB = 1 -> ExpSet = 1, ExpDiff = 253.
  - ExpA = 0, ExpB = 255 -> ExpSet = 0, ExpDiff = 255, ExpMax = 255.
- Handshake: apply InValid = 1, 0, 1 with pairs (10, 20) and (50, 5).
  - OutValid follows 1, 0, 1, each one cycle late.
  - During the idle cycle, outputs hold ExpSet = 0, ExpDiff = 10.
  - Then ExpSet = 1, ExpDiff = 45.
- Reset mid-stream: drive Reset_n = 0 together with InValid = 1 and (200, 3).
  - Next edge gives OutValid = 0 and all outputs 0.
  - After Reset_n = 1, the first valid op produces correct results one cycle later.
